// File: rtl/zoechip_digit_seq.sv
// zoechip_digit_seq: 4-bit digit source for the seven-segment decoder stage.
// Advances from a prescaler while running, or by a debounced step button.
module zoechip_digit_seq #(
   parameter int MAX_COUNT = 1000,
   parameter int DEBOUNCE  = 16
) (
   input  logic [7:0] io_in,
   output logic [7:0] io_out
);

   localparam logic [15:0] PRESC_LAST = 16'(MAX_COUNT - 1);
   localparam logic [7:0]  DB_LAST    = 8'(DEBOUNCE - 1);

   // synchronized input bit positions
   localparam int S_RUN  = 0;
   localparam int S_DIR  = 1;
   localparam int S_STEP = 2;
   localparam int S_HEX  = 3;
   localparam int S_CLR  = 4;

   typedef enum logic {
      PAUSED  = 1'b0,
      RUNNING = 1'b1
   } state_t;

   logic clk;
   logic rst;
   logic unused_in;

   assign clk       = io_in[0];
   assign rst       = io_in[1];
   assign unused_in = io_in[7];

   logic [4:0] sync_a;
   logic [4:0] sync_b;

   logic run_s;
   logic dir_s;
   logic step_s;
   logic hex_s;
   logic clr_s;

   logic [1:0]      btn_s;
   logic [1:0][7:0] db_cnt;
   logic [1:0]      db_lvl;
   logic [1:0]      db_dly;
   logic            run_edge;
   logic            step_edge;

   state_t state;
   state_t state_nxt;
   logic   running;

   logic [15:0] presc;
   logic        tick;

   logic       adv;
   logic [3:0] limit;
   logic [3:0] nxt_digit;
   logic       nxt_wrap;

   logic [3:0] digit;
   logic       upd;
   logic       cry;
   logic       hb;

   // two-flop synchronizers for the five live pins
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_a <= '0;
         sync_b <= '0;
      end else begin
         sync_a <= io_in[6:2];
         sync_b <= sync_a;
      end
   end

   assign run_s  = sync_b[S_RUN];
   assign dir_s  = sync_b[S_DIR];
   assign step_s = sync_b[S_STEP];
   assign hex_s  = sync_b[S_HEX];
   assign clr_s  = sync_b[S_CLR];

   assign btn_s = {step_s, run_s};

   // debounce run (0) and step (1): flip level after DEBOUNCE differing cycles
   always_ff @(posedge clk) begin
      if (rst) begin
         db_cnt <= '0;
         db_lvl <= '0;
         db_dly <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (btn_s[i] == db_lvl[i]) begin
               db_cnt[i] <= 8'd0;
            end else if (db_cnt[i] == DB_LAST) begin
               db_cnt[i] <= 8'd0;
               db_lvl[i] <= btn_s[i];
            end else begin
               db_cnt[i] <= db_cnt[i] + 8'd1;
            end
         end
         db_dly <= db_lvl;
      end
   end

   assign run_edge  = db_lvl[0] & ~db_dly[0];
   assign step_edge = db_lvl[1] & ~db_dly[1];

   // run/pause state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= PAUSED;
      end else begin
         state <= state_nxt;
      end
   end

   // each debounced run press toggles between paused and running
   always_comb begin
      state_nxt = state;
      unique case (state)
         PAUSED:  if (run_edge) state_nxt = RUNNING;
         RUNNING: if (run_edge) state_nxt = PAUSED;
         default: state_nxt = PAUSED;
      endcase
   end

   // state decode used by the datapath and the run indicator
   always_comb begin
      running = 1'b0;
      unique case (state)
         RUNNING: running = 1'b1;
         default: running = 1'b0;
      endcase
   end

   // tick on the last prescaler count; clear suppresses it entirely
   assign tick = running & ~clr_s & (presc == PRESC_LAST);

   // prescaler only runs while running and not cleared
   always_ff @(posedge clk) begin
      if (rst) begin
         presc <= 16'd0;
      end else if (clr_s || !running || tick) begin
         presc <= 16'd0;
      end else begin
         presc <= presc + 16'd1;
      end
   end

   // step presses only count while paused; clear overrides any advance
   assign adv = (tick | (step_edge & ~running)) & ~clr_s;

   // next digit and wrap flag for the current dir/hex setting
   always_comb begin
      limit     = hex_s ? 4'd15 : 4'd9;
      nxt_digit = digit;
      nxt_wrap  = 1'b0;
      if (!dir_s) begin
         if (digit >= limit) begin
            nxt_digit = 4'd0;
            nxt_wrap  = 1'b1;
         end else begin
            nxt_digit = digit + 4'd1;
         end
      end else begin
         if (digit == 4'd0) begin
            nxt_digit = limit;
            nxt_wrap  = 1'b1;
         end else if (digit > limit) begin
            // left over from hex mode: fall into decimal range quietly
            nxt_digit = 4'd9;
         end else begin
            nxt_digit = digit - 4'd1;
         end
      end
   end

   // digit register with one-cycle update/carry strobes
   always_ff @(posedge clk) begin
      if (rst) begin
         digit <= 4'd0;
         upd   <= 1'b0;
         cry   <= 1'b0;
      end else begin
         upd <= adv;
         cry <= adv & nxt_wrap;
         if (clr_s) begin
            digit <= 4'd0;
         end else if (adv) begin
            digit <= nxt_digit;
         end
      end
   end

   // heartbeat toggles once per prescaler tick
   always_ff @(posedge clk) begin
      if (rst) begin
         hb <= 1'b0;
      end else if (tick) begin
         hb <= ~hb;
      end
   end

   assign io_out = {running, hb, cry, upd, digit};

endmodule

// File: tb/tb_zoechip_digit_seq.sv
// tb_zoechip_digit_seq: directed checks of the digit sequencer
// with MAX_COUNT=4 and DEBOUNCE=2.
module tb_zoechip_digit_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       run_b = 1'b0;
   logic       dir = 1'b0;
   logic       step_b = 1'b0;
   logic       hex = 1'b0;
   logic       clr = 1'b0;
   logic [7:0] io_in;
   logic [7:0] io_out;

   int checks = 0;
   int errors = 0;

   assign io_in = {1'b0, clr, hex, step_b, dir, run_b, rst, clk};

   zoechip_digit_seq #(
      .MAX_COUNT(4),
      .DEBOUNCE(2)
   ) dut (
      .io_in(io_in),
      .io_out(io_out)
   );

   always #5 clk = ~clk;

   task automatic wait_edges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press_step();
      step_b = 1'b1;
      wait_edges(5);
      step_b = 1'b0;
      wait_edges(6);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      wait_edges(2);
      rst = 1'b0;
      checks++;
      if (io_out !== 8'h00) begin
         errors++;
         $display("FAIL reset: got %h want 00", io_out);
      end
   endtask

   task automatic test_run_auto();
      run_b = 1'b1;
      wait_edges(4);
      checks++;
      if (io_out[7] !== 1'b0) begin
         errors++;
         $display("FAIL run_early: got %b want 0", io_out[7]);
      end
      wait_edges(1);
      checks++;
      if (io_out !== 8'h80) begin
         errors++;
         $display("FAIL run_on: got %h want 80", io_out);
      end
      wait_edges(3);
      checks++;
      if (io_out !== 8'h80) begin
         errors++;
         $display("FAIL first_tick_early: got %h want 80", io_out);
      end
      wait_edges(1);
      checks++;
      if (io_out !== 8'hD1) begin
         errors++;
         $display("FAIL first_tick: got %h want d1", io_out);
      end
      wait_edges(1);
      checks++;
      if (io_out !== 8'hC1) begin
         errors++;
         $display("FAIL strobe_len: got %h want c1", io_out);
      end
      run_b = 1'b0;
      wait_edges(3);
      checks++;
      if (io_out !== 8'h92) begin
         errors++;
         $display("FAIL tick2: got %h want 92", io_out);
      end
      wait_edges(4);
      checks++;
      if (io_out !== 8'hD3) begin
         errors++;
         $display("FAIL tick3: got %h want d3", io_out);
      end
   endtask

   task automatic test_wrap();
      wait_edges(24);
      checks++;
      if (io_out !== 8'hD9) begin
         errors++;
         $display("FAIL dec_nine: got %h want d9", io_out);
      end
      wait_edges(4);
      checks++;
      if (io_out !== 8'hB0) begin
         errors++;
         $display("FAIL dec_carry: got %h want b0", io_out);
      end
      wait_edges(1);
      checks++;
      if (io_out !== 8'h80) begin
         errors++;
         $display("FAIL carry_len: got %h want 80", io_out);
      end
      hex = 1'b1;
      wait_edges(59);
      checks++;
      if (io_out !== 8'hDF) begin
         errors++;
         $display("FAIL hex_fifteen: got %h want df", io_out);
      end
      wait_edges(4);
      checks++;
      if (io_out !== 8'hB0) begin
         errors++;
         $display("FAIL hex_carry: got %h want b0", io_out);
      end
      dir = 1'b1;
      wait_edges(4);
      checks++;
      if (io_out !== 8'hFF) begin
         errors++;
         $display("FAIL hex_borrow: got %h want ff", io_out);
      end
   endtask

   task automatic test_pause();
      run_b = 1'b1;
      wait_edges(4);
      checks++;
      if (io_out !== 8'h9E) begin
         errors++;
         $display("FAIL down_tick: got %h want 9e", io_out);
      end
      wait_edges(1);
      checks++;
      if (io_out !== 8'h0E) begin
         errors++;
         $display("FAIL pause: got %h want 0e", io_out);
      end
      run_b = 1'b0;
      wait_edges(10);
      checks++;
      if (io_out !== 8'h0E) begin
         errors++;
         $display("FAIL paused_hold: got %h want 0e", io_out);
      end
      dir = 1'b0;
   endtask

   task automatic test_step();
      step_b = 1'b1;
      wait_edges(1);
      step_b = 1'b0;
      wait_edges(8);
      checks++;
      if (io_out !== 8'h0E) begin
         errors++;
         $display("FAIL short_pulse: got %h want 0e", io_out);
      end
      step_b = 1'b1;
      wait_edges(4);
      checks++;
      if (io_out !== 8'h0E) begin
         errors++;
         $display("FAIL step_early: got %h want 0e", io_out);
      end
      wait_edges(1);
      checks++;
      if (io_out !== 8'h1F) begin
         errors++;
         $display("FAIL step: got %h want 1f", io_out);
      end
      wait_edges(1);
      checks++;
      if (io_out !== 8'h0F) begin
         errors++;
         $display("FAIL step_strobe: got %h want 0f", io_out);
      end
      wait_edges(4);
      step_b = 1'b0;
      wait_edges(8);
      checks++;
      if (io_out !== 8'h0F) begin
         errors++;
         $display("FAIL step_once: got %h want 0f", io_out);
      end
   endtask

   task automatic test_step_running();
      run_b = 1'b1;
      wait_edges(5);
      checks++;
      if (io_out !== 8'h8F) begin
         errors++;
         $display("FAIL resume: got %h want 8f", io_out);
      end
      run_b = 1'b0;
      step_b = 1'b1;
      wait_edges(4);
      checks++;
      if (io_out !== 8'hF0) begin
         errors++;
         $display("FAIL resume_tick: got %h want f0", io_out);
      end
      wait_edges(1);
      checks++;
      if (io_out !== 8'hC0) begin
         errors++;
         $display("FAIL step_ignored: got %h want c0", io_out);
      end
      wait_edges(2);
      checks++;
      if (io_out !== 8'hC0) begin
         errors++;
         $display("FAIL step_ignored2: got %h want c0", io_out);
      end
      wait_edges(1);
      checks++;
      if (io_out !== 8'h91) begin
         errors++;
         $display("FAIL tick_after_step: got %h want 91", io_out);
      end
      wait_edges(2);
      step_b = 1'b0;
   endtask

   task automatic test_clear();
      wait_edges(22);
      checks++;
      if (io_out !== 8'h97) begin
         errors++;
         $display("FAIL at_seven: got %h want 97", io_out);
      end
      clr = 1'b1;
      wait_edges(2);
      checks++;
      if (io_out !== 8'h87) begin
         errors++;
         $display("FAIL clear_early: got %h want 87", io_out);
      end
      wait_edges(1);
      checks++;
      if (io_out !== 8'h80) begin
         errors++;
         $display("FAIL clear: got %h want 80", io_out);
      end
      wait_edges(20);
      checks++;
      if (io_out !== 8'h80) begin
         errors++;
         $display("FAIL clear_hold: got %h want 80", io_out);
      end
      clr = 1'b0;
      wait_edges(5);
      checks++;
      if (io_out !== 8'h80) begin
         errors++;
         $display("FAIL release_early: got %h want 80", io_out);
      end
      wait_edges(1);
      checks++;
      if (io_out !== 8'hD1) begin
         errors++;
         $display("FAIL release_tick: got %h want d1", io_out);
      end
   endtask

   task automatic test_mode_switch();
      wait_edges(41);
      run_b = 1'b1;
      wait_edges(3);
      checks++;
      if (io_out !== 8'h9C) begin
         errors++;
         $display("FAIL at_twelve: got %h want 9c", io_out);
      end
      wait_edges(2);
      checks++;
      if (io_out !== 8'h0C) begin
         errors++;
         $display("FAIL pause12: got %h want 0c", io_out);
      end
      run_b = 1'b0;
      hex = 1'b0;
      dir = 1'b1;
      step_b = 1'b1;
      wait_edges(5);
      checks++;
      if (io_out !== 8'h19) begin
         errors++;
         $display("FAIL hex_to_dec_down: got %h want 19", io_out);
      end
      step_b = 1'b0;
      wait_edges(6);
      hex = 1'b1;
      dir = 1'b0;
      for (int i = 0; i < 3; i++) press_step();
      checks++;
      if (io_out !== 8'h0C) begin
         errors++;
         $display("FAIL restep12: got %h want 0c", io_out);
      end
      hex = 1'b0;
      step_b = 1'b1;
      wait_edges(5);
      checks++;
      if (io_out !== 8'h30) begin
         errors++;
         $display("FAIL hex_to_dec_up: got %h want 30", io_out);
      end
      step_b = 1'b0;
      wait_edges(6);
   endtask

   task automatic test_simultaneous();
      run_b = 1'b1;
      step_b = 1'b1;
      wait_edges(4);
      checks++;
      if (io_out !== 8'h00) begin
         errors++;
         $display("FAIL simul_early: got %h want 00", io_out);
      end
      wait_edges(1);
      checks++;
      if (io_out !== 8'h91) begin
         errors++;
         $display("FAIL simul: got %h want 91", io_out);
      end
      run_b = 1'b0;
      step_b = 1'b0;
   endtask

   task automatic test_reset_mid();
      wait_edges(2);
      run_b = 1'b1;
      wait_edges(3);
      rst = 1'b1;
      wait_edges(1);
      checks++;
      if (io_out !== 8'h00) begin
         errors++;
         $display("FAIL mid_reset: got %h want 00", io_out);
      end
      wait_edges(1);
      rst = 1'b0;
      wait_edges(4);
      checks++;
      if (io_out !== 8'h00) begin
         errors++;
         $display("FAIL held_early: got %h want 00", io_out);
      end
      wait_edges(1);
      checks++;
      if (io_out !== 8'h80) begin
         errors++;
         $display("FAIL held_press: got %h want 80", io_out);
      end
      run_b = 1'b0;
      wait_edges(4);
   endtask

   initial begin
      test_reset();
      test_run_auto();
      test_wrap();
      test_pause();
      test_step();
      test_step_running();
      test_clear();
      test_mode_switch();
      test_simultaneous();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
